// File: rtl/ad7324_spi_responder_pkg.sv
// Shared definitions for the AD7324 SPI responder: FSM encoding, frame geometry,
// and control-word field positions.
package ad7324_spi_responder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  localparam int FRAME_BITS_DEFAULT = 16;
  localparam int DATA_W_DEFAULT     = 13;

  localparam int WRITE_BIT = 15;
  localparam int REGSEL_HI = 14;
  localparam int REGSEL_LO = 13;
  localparam int ADD_HI    = 11;
  localparam int ADD_LO    = 10;
  localparam int SEQ_HI    = 3;
  localparam int SEQ_LO    = 2;

  localparam logic [1:0] REGSEL_CTRL = 2'b00;
  localparam logic [1:0] SEQ_ENABLE  = 2'b11;

  // Sequencer walks 0..last and wraps back to channel 0
  function automatic logic [1:0] next_seq_ch(input logic [1:0] cur, input logic [1:0] last);
    return (cur == last) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/ad7324_spi_responder_spi_in_sync.sv
// Multi-flop synchronizer with rise/fall detection for one SPI input.
// Edges are suppressed until the chain has refilled after reset, so a pin already low at release is not an edge.
module ad7324_spi_responder_spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic [SETTLE_W-1:0]    settle;
  logic                   armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
      settle <= '0;
    end else begin
      chain <= SYNC_STAGES'({chain, d});
      prev  <= chain[SYNC_STAGES-1];
      if (settle != SETTLE_MAX) settle <= settle + 1'b1;
    end
  end

  assign armed = (settle == SETTLE_MAX);
  assign q     = chain[SYNC_STAGES-1];
  assign rise  = armed & q & ~prev;
  assign fall  = armed & ~q & prev;

endmodule

// File: rtl/ad7324_spi_responder.sv
// AD7324 ADC emulator: SPI slave that returns {0, channel id, channel data} per CS window,
// decodes control-register writes from DIN and runs the channel sequencer.
module ad7324_spi_responder
  import ad7324_spi_responder_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RSTp,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              DIN,
  input  logic [DATA_W-1:0] CH0_DATA,
  input  logic [DATA_W-1:0] CH1_DATA,
  input  logic [DATA_W-1:0] CH2_DATA,
  input  logic [DATA_W-1:0] CH3_DATA,
  output logic              DOUT,
  output logic              DOUT_OE,
  output logic [11:0]       CTRL_REG,
  output logic [1:0]        CUR_CH,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic din_s, din_rise, din_fall;

  ad7324_spi_responder_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(CLK), .rst(RSTp), .d(CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall));

  ad7324_spi_responder_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk(CLK), .rst(RSTp), .d(SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

  ad7324_spi_responder_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
    .clk(CLK), .rst(RSTp), .d(DIN), .q(din_s), .rise(din_rise), .fall(din_fall));

  logic unused_sync;
  assign unused_sync = ^{cs_s, sclk_s, sclk_rise, din_rise, din_fall};

  state_t                state, next_state;
  logic [FRAME_BITS-1:0] tx_sh, rx_sh;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  seq_mode;
  logic [1:0]            last_ch;
  logic [DATA_W-1:0]     ch_sel;

  always_comb begin
    ch_sel = CH0_DATA;
    case (CUR_CH)
      2'd1:    ch_sel = CH1_DATA;
      2'd2:    ch_sel = CH2_DATA;
      2'd3:    ch_sel = CH3_DATA;
      default: ch_sel = CH0_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTp) state <= IDLE;
    else      state <= next_state;
  end

  // An early CS rise takes priority over a coincident SCLK edge, so short frames always abort
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cs_fall) next_state = SHIFT;
      SHIFT: begin
        if (cs_rise)                             next_state = IDLE;
        else if (sclk_fall && bit_cnt == LAST_BIT) next_state = DONE_WAIT;
      end
      DONE_WAIT: if (cs_rise) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTp) begin
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= '0;
      DOUT       <= 1'b0;
      DOUT_OE    <= 1'b0;
      CTRL_REG   <= '0;
      CUR_CH     <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      seq_mode   <= 1'b0;
      last_ch    <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_sh   <= FRAME_BITS'({1'b0, CUR_CH, ch_sel});
            DOUT    <= 1'b0;
            DOUT_OE <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            FRAME_ERR <= 1'b1;
            DOUT_OE   <= 1'b0;
          end else if (sclk_fall) begin
            rx_sh   <= {rx_sh[FRAME_BITS-2:0], din_s};
            tx_sh   <= tx_sh << 1;
            bit_cnt <= bit_cnt + 1'b1;
            // The final edge leaves data bit 0 on the line until CS rises
            if (bit_cnt != LAST_BIT) DOUT <= tx_sh[FRAME_BITS-2];
          end
        end
        DONE_WAIT: begin
          if (cs_rise) begin
            FRAME_DONE <= 1'b1;
            DOUT_OE    <= 1'b0;
            if (rx_sh[WRITE_BIT] && rx_sh[REGSEL_HI:REGSEL_LO] == REGSEL_CTRL) begin
              CTRL_REG <= rx_sh[11:0];
              if (rx_sh[SEQ_HI:SEQ_LO] == SEQ_ENABLE) begin
                seq_mode <= 1'b1;
                last_ch  <= rx_sh[ADD_HI:ADD_LO];
                CUR_CH   <= 2'd0;
              end else begin
                seq_mode <= 1'b0;
                CUR_CH   <= rx_sh[ADD_HI:ADD_LO];
              end
            end else if (seq_mode) begin
              CUR_CH <= next_seq_ch(CUR_CH, last_ch);
            end
          end
        end
        default: DOUT_OE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7324_spi_responder.sv
// Directed bench for the AD7324 responder: a small SPI master plus a channel/sequencer model
// whose expected frames go through a scoreboard queue.
module tb_ad7324_spi_responder;

  logic        CLK = 1'b0;
  logic        RSTp, CS, SCLK, DIN;
  logic [12:0] ch_data [4];
  logic        DOUT, DOUT_OE, FRAME_DONE, FRAME_ERR;
  logic [11:0] CTRL_REG;
  logic [1:0]  CUR_CH;

  ad7324_spi_responder dut (
    .CLK(CLK), .RSTp(RSTp), .CS(CS), .SCLK(SCLK), .DIN(DIN),
    .CH0_DATA(ch_data[0]), .CH1_DATA(ch_data[1]), .CH2_DATA(ch_data[2]), .CH3_DATA(ch_data[3]),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE), .CTRL_REG(CTRL_REG), .CUR_CH(CUR_CH),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge CLK) begin
    if (FRAME_DONE) done_cnt++;
    if (FRAME_ERR)  err_cnt++;
  end

  logic [15:0] exp_q [$];
  logic [1:0]  m_ch, m_last;
  logic        m_seq;
  logic [11:0] m_ctrl;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    m_ch = 2'd0; m_last = 2'd0; m_seq = 1'b0; m_ctrl = 12'h000;
  endtask

  task automatic model_update(input logic [15:0] w);
    if (w[15] && w[14:13] == 2'b00) begin
      m_ctrl = w[11:0];
      if (w[3:2] == 2'b11) begin
        m_seq = 1'b1; m_last = w[11:10]; m_ch = 2'd0;
      end else begin
        m_seq = 1'b0; m_ch = w[11:10];
      end
    end else if (m_seq) begin
      m_ch = (m_ch == m_last) ? 2'd0 : m_ch + 2'd1;
    end
  endtask

  // Master reads DOUT just before each SCLK fall and presents DIN while SCLK is high
  task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] rd);
    rd = '0;
    for (int k = 0; k < n; k++) begin
      DIN = w[15-k];
      wait_clk(2);
      rd[15-k] = DOUT;
      SCLK = 1'b0;
      wait_clk(4);
      SCLK = 1'b1;
      wait_clk(2);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] w, input logic mutate);
    logic [15:0] rd, exp_word;
    int d0, e0;
    exp_q.push_back({1'b0, m_ch, ch_data[m_ch]});
    exp_word = exp_q[exp_q.size()-1];
    d0 = done_cnt; e0 = err_cnt;
    CS = 1'b0;
    wait_clk(4);
    check_output("dout_oe_active", DOUT_OE, 1);
    if (mutate) ch_data[m_ch] = ~ch_data[m_ch];
    shift_bits(w, 16, rd);
    check_output("dout_hold_bit0", DOUT, exp_word[0]);
    CS = 1'b1;
    wait_clk(8);
    exp_word = exp_q.pop_front();
    check_output("frame_data", rd, exp_word);
    check_output("frame_done_pulses", done_cnt - d0, 1);
    check_output("frame_err_pulses", err_cnt - e0, 0);
    check_output("dout_oe_idle", DOUT_OE, 0);
    model_update(w);
    check_output("cur_ch", CUR_CH, m_ch);
    check_output("ctrl_reg", CTRL_REG, m_ctrl);
  endtask

  initial begin
    logic [15:0] rd, exp_word;
    int d0, e0;
    $display("[TB] start");
    ch_data[0] = 13'h0ABC; ch_data[1] = 13'h0123;
    ch_data[2] = 13'h1FFF; ch_data[3] = 13'h1000;
    RSTp = 1'b1; CS = 1'b1; SCLK = 1'b1; DIN = 1'b0;
    model_reset();
    wait_clk(4);
    check_output("rst_dout", DOUT, 0);
    check_output("rst_dout_oe", DOUT_OE, 0);
    check_output("rst_ctrl_reg", CTRL_REG, 0);
    check_output("rst_cur_ch", CUR_CH, 0);
    check_output("rst_frame_done", FRAME_DONE, 0);
    check_output("rst_frame_err", FRAME_ERR, 0);
    RSTp = 1'b0;
    wait_clk(6);

    $display("[TB] plain data frame and fixed-channel write");
    apply_stimulus(16'h0000, 1'b0);
    apply_stimulus(16'h8800, 1'b0);
    apply_stimulus(16'h0000, 1'b0);
    apply_stimulus(16'h0000, 1'b1);

    $display("[TB] sequencer over channels 0..3");
    apply_stimulus(16'h8C0C, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(16'h0000, 1'b0);

    $display("[TB] aborted frame");
    exp_word = {1'b0, m_ch, ch_data[m_ch]};
    d0 = done_cnt; e0 = err_cnt;
    CS = 1'b0;
    wait_clk(4);
    shift_bits(16'h8800, 7, rd);
    CS = 1'b1;
    wait_clk(8);
    check_output("abort_partial_bits", rd[15:9], exp_word[15:9]);
    check_output("abort_err_pulses", err_cnt - e0, 1);
    check_output("abort_done_pulses", done_cnt - d0, 0);
    check_output("abort_dout_oe", DOUT_OE, 0);
    check_output("abort_cur_ch", CUR_CH, m_ch);
    check_output("abort_ctrl_reg", CTRL_REG, m_ctrl);
    apply_stimulus(16'h0000, 1'b0);

    $display("[TB] other-register write");
    apply_stimulus(16'hA000, 1'b0);

    $display("[TB] reset mid-frame");
    d0 = done_cnt;
    CS = 1'b0;
    wait_clk(4);
    shift_bits(16'h8000, 9, rd);
    RSTp = 1'b1;
    wait_clk(1);
    check_output("midrst_dout_oe", DOUT_OE, 0);
    check_output("midrst_cur_ch", CUR_CH, 0);
    check_output("midrst_ctrl_reg", CTRL_REG, 0);
    check_output("midrst_dout", DOUT, 0);
    RSTp = 1'b0;
    model_reset();
    wait_clk(6);
    check_output("cs_low_after_rst_oe", DOUT_OE, 0);
    CS = 1'b1;
    wait_clk(8);
    check_output("midrst_no_done", done_cnt - d0, 0);
    apply_stimulus(16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
